imm_pack: RTL

- Inverse of the immediate extender: takes a 32-bit signed immediate plus an immediate type and scatters it into the instruction's immediate bit positions over a base instruction word.
- Used by the instruction-memory preload/self-test path to assemble RISC-V instructions on the fly.
- Two-stage valid/ready pipeline with range and alignment checking.
- Round-trip property: for every error-free result, extending instr[31:7] with the same type returns the original imm_value.

---
 rtl/imm_pack_if.sv | 23 ++
 rtl/imm_pack.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/imm_pack_if.sv
// imm_pack_if: request/response bundle for the immediate packer.
// slave is the packer side. master is the requester/consumer side.
interface imm_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_src;
  logic [31:0] imm_value;
  logic [31:0] base_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [1:0]  err_code;

  modport slave (
    input  in_valid, imm_src, imm_value, base_word, out_ready,
    output in_ready, out_valid, instr, err_code
  );

  modport master (
    output in_valid, imm_src, imm_value, base_word, out_ready,
    input  in_ready, out_valid, instr, err_code
  );
endinterface

// File: rtl/imm_pack.sv
// imm_pack: scatters a signed immediate into the RISC-V immediate fields of a
// base instruction word. This is the inverse of the immediate extender.
// Two-stage valid/ready pipeline:
//   S1 captures the request and its error code.
//   S2 holds the packed word.
// Optional macro IMM_PACK_STATS_EN adds the saturating pack/error counters.
module imm_pack #(
  parameter int COUNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  imm_pack_if.slave bus
`ifdef IMM_PACK_STATS_EN
  ,
  output logic [COUNT_W-1:0] pack_count,
  output logic [COUNT_W-1:0] err_count
`endif
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_J = 3'b011;
  localparam logic [2:0] SRC_U = 3'b100;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  if (COUNT_W < 1) begin : g_bad_count_w
    $error("imm_pack: COUNT_W must be at least 1");
  end

  logic        r_s1_valid;
  logic [2:0]  r_s1_src;
  logic [31:0] r_s1_imm;
  logic [31:0] r_s1_base;
  logic [1:0]  r_s1_err;
  logic        r_s2_valid;
  logic [31:0] r_instr;
  logic [1:0]  r_err;

  logic        w_adv;
  logic        w_s1_load;
  logic        w_sx11;
  logic        w_sx12;
  logic        w_sx20;
  logic [1:0]  w_err;
  logic [31:0] w_pack;

  // S2 frees up when it is empty or its result is being taken.
  // S1 shifts in lockstep with S2, or fills an empty slot.
  assign w_adv      = !r_s2_valid || bus.out_ready;
  assign w_s1_load  = !r_s1_valid || w_adv;
  assign bus.in_ready  = w_s1_load;
  assign bus.out_valid = r_s2_valid;
  assign bus.instr     = r_instr;
  assign bus.err_code  = r_err;

  // Sign-extension tests. The bits above the field's top bit must all copy
  // that top bit.
  assign w_sx11 = (&bus.imm_value[31:11]) | ~(|bus.imm_value[31:11]);
  assign w_sx12 = (&bus.imm_value[31:12]) | ~(|bus.imm_value[31:12]);
  assign w_sx20 = (&bus.imm_value[31:20]) | ~(|bus.imm_value[31:20]);

  // Classify the incoming request. Priority is illegal, then range, then alignment.
  always_comb begin
    w_err = ERR_OK;
    case (bus.imm_src)
      SRC_I, SRC_S: if (!w_sx11) w_err = ERR_RANGE;
      SRC_B: begin
        if (!w_sx12)                 w_err = ERR_RANGE;
        else if (bus.imm_value[0])   w_err = ERR_ALIGN;
      end
      SRC_J: begin
        if (!w_sx20)                 w_err = ERR_RANGE;
        else if (bus.imm_value[0])   w_err = ERR_ALIGN;
      end
      SRC_U: if (bus.imm_value[11:0] != 12'h000) w_err = ERR_ALIGN;
      default: w_err = ERR_ILL;
    endcase
  end

  // Scatter the S1 immediate over the base word.
  // Out-of-range bits are simply dropped. An illegal type passes the base word through.
  always_comb begin
    w_pack = r_s1_base;
    case (r_s1_src)
      SRC_I: w_pack[31:20] = r_s1_imm[11:0];
      SRC_S: begin
        w_pack[31:25] = r_s1_imm[11:5];
        w_pack[11:7]  = r_s1_imm[4:0];
      end
      SRC_B: begin
        w_pack[31]    = r_s1_imm[12];
        w_pack[30:25] = r_s1_imm[10:5];
        w_pack[11:8]  = r_s1_imm[4:1];
        w_pack[7]     = r_s1_imm[11];
      end
      SRC_J: begin
        w_pack[31]    = r_s1_imm[20];
        w_pack[30:21] = r_s1_imm[10:1];
        w_pack[20]    = r_s1_imm[11];
        w_pack[19:12] = r_s1_imm[19:12];
      end
      SRC_U: w_pack[31:12] = r_s1_imm[31:12];
      default: ;
    endcase
  end

  // S1 valid bit. This clears on reset, so in-flight work is discarded.
  always_ff @(posedge clk) begin
    if (!rst_n)         r_s1_valid <= 1'b0;
    else if (w_s1_load) r_s1_valid <= bus.in_valid;
  end

  // S1 payload. It is qualified by r_s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_s1_load && bus.in_valid) begin
      r_s1_src  <= bus.imm_src;
      r_s1_imm  <= bus.imm_value;
      r_s1_base <= bus.base_word;
      r_s1_err  <= w_err;
    end
  end

  // S2 output register. It is held while stalled, so instr/err_code stay stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_instr    <= '0;
      r_err      <= ERR_OK;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_instr <= w_pack;
        r_err   <= r_s1_err;
      end
    end
  end

`ifdef IMM_PACK_STATS_EN
  logic [COUNT_W-1:0] r_pack_cnt;
  logic [COUNT_W-1:0] r_err_cnt;
  logic               w_out_xfer;

  assign w_out_xfer = r_s2_valid && bus.out_ready;
  assign pack_count = r_pack_cnt;
  assign err_count  = r_err_cnt;

  // Saturating counters of delivered results and of delivered errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pack_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_out_xfer) begin
      if (r_pack_cnt != '1) r_pack_cnt <= r_pack_cnt + 1'b1;
      if ((r_err != ERR_OK) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end
`endif

endmodule
